// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer with stall, reset vector, increment and circular return-address stack.
// Latency : one clock from phase/control inputs to the registered pc; ras_top/ras_cnt follow the same edge.
// Backpr. : stall=1 freezes every register (pc, RAS, sticky flags); hlt still wins over stall.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   hlt               synchronous halt/restart: pc to RESET_VEC, RAS and flags cleared
//   phase             current phase, one-hot (PH_F fetch, PH_W write-back)
//   stall             hold all state this cycle
//   ct_taken, is_call, is_ret   control-transfer qualifiers, sampled in PH_W
//   dr                target address from the datapath
//   pc                registered program counter
//   ras_top           most recently pushed, not yet popped entry (0 when empty)
//   ras_cnt           number of valid RAS entries, 0..RAS_DEPTH
//   ras_ovf, ras_unf  sticky overflow (push while full) / underflow (return while empty)
//
// Optional feature macro PC_SEQ_TRAP_EN: adds TRAP_VEC, input trap and output epc.

module pc_sequencer #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       INC       = 1,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter int unsigned       CW        = $clog2(RAS_DEPTH) + 1
`ifdef PC_SEQ_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h10)
`endif
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hlt,
  input  logic [4:0]       phase,
  input  logic             stall,
  input  logic             ct_taken,
  input  logic             is_call,
  input  logic             is_ret,
  input  logic [WIDTH-1:0] dr,
`ifdef PC_SEQ_TRAP_EN
  input  logic             trap,
  output logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ras_top,
  output logic [CW-1:0]    ras_cnt,
  output logic             ras_ovf,
  output logic             ras_unf
);

  // Phase encodings mirror header.v (one-hot phase counter).
  localparam logic [4:0] PH_F = 5'b00001;
  localparam logic [4:0] PH_W = 5'b10000;

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;      // next free slot; top entry lives at sp_q-1
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];

  logic [PW-1:0]    top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic             trap_hit;
  logic             do_push;

`ifdef PC_SEQ_TRAP_EN
  logic [WIDTH-1:0] epc_q, epc_d;
  assign trap_hit = trap;
  assign epc      = epc_q;
`else
  assign trap_hit = 1'b0;
`endif

  assign top_idx   = sp_q - PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

  assign pc      = pc_q;
  assign ras_top = ras_empty ? '0 : mem_q[top_idx];
  assign ras_cnt = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mem_d   = mem_q;
    do_push = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    epc_d   = epc_q;
`endif

    if (hlt) begin
      pc_d  = RESET_VEC;
      sp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_d[i] = '0;
`ifdef PC_SEQ_TRAP_EN
      epc_d = '0;
`endif
    end else if (stall) begin
      // hold everything
    end else if (trap_hit) begin
      // A trap pre-empts the phase action and any RAS traffic.
`ifdef PC_SEQ_TRAP_EN
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
`endif
    end else if (phase == PH_F) begin
      pc_d = pc_q + WIDTH'(INC);
    end else if (phase == PH_W && ct_taken) begin
      unique case ({is_call, is_ret})
        2'b00: pc_d = dr;
        2'b10: do_push = 1'b1;
        2'b01: begin
          if (!ras_empty) begin
            pc_d  = mem_q[top_idx];
            sp_d  = top_idx;
            cnt_d = cnt_q - CW'(1);
          end else begin
            // Nothing to return to: fall back to the datapath target.
            pc_d  = dr;
            unf_d = 1'b1;
          end
        end
        default: begin
          // Coroutine swap: exchange pc with the top entry in place.
          if (!ras_empty) begin
            pc_d           = mem_q[top_idx];
            mem_d[top_idx] = pc_q;
          end else begin
            do_push = 1'b1;
          end
        end
      endcase

      // pc_q already holds the return address (incremented during PH_F).
      // When full the write lands on the oldest slot, so the ring just rotates.
      if (do_push) begin
        pc_d        = dr;
        mem_d[sp_q] = pc_q;
        sp_d        = sp_q + PW'(1);
        if (ras_full) ovf_d = 1'b1;
        else          cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
`ifdef PC_SEQ_TRAP_EN
      epc_q <= '0;
`endif
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mem_q <= mem_d;
`ifdef PC_SEQ_TRAP_EN
      epc_q <= epc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer (WIDTH=8, RAS_DEPTH=4) against a queue-based model.
// Latency : outputs compared on every falling edge, half a cycle after the updating edge.
// Backpr. : stall/hlt randomised alongside directed scenarios.
module tb_pc_sequencer;

  localparam logic [4:0] PH_F = 5'b00001;
  localparam logic [4:0] PH_D = 5'b00010;
  localparam logic [4:0] PH_W = 5'b10000;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TVEC  = 8'h10;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hlt = 1'b0;
  logic [4:0] phase = PH_D;
  logic       stall = 1'b0;
  logic       ct_taken = 1'b0;
  logic       is_call = 1'b0;
  logic       is_ret = 1'b0;
  logic [7:0] dr = 8'h00;
  logic       trap = 1'b0;
  logic [7:0] pc;
  logic [7:0] ras_top;
  logic [2:0] ras_cnt;
  logic       ras_ovf;
  logic       ras_unf;
`ifdef PC_SEQ_TRAP_EN
  logic [7:0] epc;
`endif

  int errs = 0;
  int checks = 0;

  pc_sequencer #(
    .WIDTH(8), .RESET_VEC(8'h00), .INC(1), .RAS_DEPTH(DEPTH)
`ifdef PC_SEQ_TRAP_EN
    , .TRAP_VEC(TVEC)
`endif
  ) dut (
    .clk(clk), .n_rst(n_rst), .hlt(hlt), .phase(phase), .stall(stall),
    .ct_taken(ct_taken), .is_call(is_call), .is_ret(is_ret), .dr(dr),
`ifdef PC_SEQ_TRAP_EN
    .trap(trap), .epc(epc),
`endif
    .pc(pc), .ras_top(ras_top), .ras_cnt(ras_cnt), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // Reference model: the stack is a queue of return addresses, newest at the back.
  logic [7:0] m_pc;
  logic [7:0] m_epc;
  logic [7:0] m_ras[$];
  logic       m_ovf, m_unf;
  logic [7:0] tmp;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst || hlt) begin
      m_pc = 8'h00; m_epc = 8'h00; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (stall) begin
      // frozen
    end else if (trap) begin
      m_epc = m_pc;
      m_pc  = TVEC;
    end else if (phase == PH_F) begin
      m_pc = m_pc + 8'd1;
    end else if (phase == PH_W && ct_taken) begin
      if (is_call && is_ret && m_ras.size() > 0) begin
        tmp = m_ras[m_ras.size()-1];
        m_ras[m_ras.size()-1] = m_pc;
        m_pc = tmp;
      end else if (is_ret && !is_call) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = dr; m_unf = 1'b1; end
      end else if (is_call) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(m_pc);
        m_pc = dr;
      end else begin
        m_pc = dr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ras_cnt", 32'(ras_cnt), 32'(m_ras.size()));
    chk("ras_top", 32'(ras_top), (m_ras.size() > 0) ? 32'(m_ras[m_ras.size()-1]) : 32'h0);
    chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    chk("ras_unf", 32'(ras_unf), 32'(m_unf));
`ifdef PC_SEQ_TRAP_EN
    chk("epc", 32'(epc), 32'(m_epc));
`endif
  end

  task automatic cyc(input logic [4:0] ph, input logic st, input logic ct,
                     input logic c, input logic r, input logic [7:0] d);
    phase = ph; stall = st; ct_taken = ct; is_call = c; is_ret = r; dr = d; hlt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    phase = PH_D; stall = 1'b0; ct_taken = 1'b0; is_call = 1'b0; is_ret = 1'b0;
  endtask

  task automatic do_hlt(input logic st);
    hlt = 1'b1; stall = st; phase = PH_F;
    @(posedge clk);
    @(negedge clk);
    hlt = 1'b0; stall = 1'b0; phase = PH_D;
  endtask

  task automatic jump(input logic [7:0] d);
    cyc(PH_W, 1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  initial begin
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_cnt", 32'(ras_cnt), 32'h0);
    chk("rst_top", 32'(ras_top), 32'h0);
    n_rst = 1'b1;

    // Fetch and halt.
    repeat (3) cyc(PH_F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fetch3", 32'(pc), 32'h3);
    do_hlt(1'b1);
    chk("hlt_pc", 32'(pc), 32'h0);
    chk("hlt_cnt", 32'(ras_cnt), 32'h0);

    // Branches.
    jump(8'h05);
    chk("jmp5", 32'(pc), 32'h5);
    jump(8'h40);
    chk("branch", 32'(pc), 32'h40);
    jump(8'h05);
    cyc(PH_W, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
    chk("not_taken", 32'(pc), 32'h5);
    cyc(PH_W, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
    chk("stalled", 32'(pc), 32'h5);

    // Call / return.
    jump(8'h11);
    cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80);
    chk("call_pc", 32'(pc), 32'h80);
    chk("call_top", 32'(ras_top), 32'h11);
    chk("call_cnt", 32'(ras_cnt), 32'h1);
    cyc(PH_W, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAD);
    chk("ret_pc", 32'(pc), 32'h11);
    chk("ret_cnt", 32'(ras_cnt), 32'h0);
    chk("ret_unf", 32'(ras_unf), 32'h0);

    // Overflow and underflow.
    for (int k = 1; k <= 5; k++) begin
      jump(8'(k));
      cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b0, 8'h60);
    end
    chk("ovf_cnt", 32'(ras_cnt), 32'h4);
    chk("ovf_flag", 32'(ras_ovf), 32'h1);
    for (int k = 5; k >= 2; k--) begin
      cyc(PH_W, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
      chk("ovf_ret", 32'(pc), 32'(k));
    end
    cyc(PH_W, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    chk("unf_pc", 32'(pc), 32'h77);
    chk("unf_flag", 32'(ras_unf), 32'h1);
    cyc(PH_W, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12);
    chk("stall_sticky", 32'(ras_cnt), 32'h0);
    do_hlt(1'b0);
    chk("hlt_unf", 32'(ras_unf), 32'h0);
    chk("hlt_ovf", 32'(ras_ovf), 32'h0);

    // Wrap and swap.
    jump(8'hFF);
    cyc(PH_F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap", 32'(pc), 32'h0);
    jump(8'h20);
    cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b0, 8'h31);
    cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
    chk("swap_pc", 32'(pc), 32'h20);
    chk("swap_top", 32'(ras_top), 32'h31);
    chk("swap_cnt", 32'(ras_cnt), 32'h1);

`ifdef PC_SEQ_TRAP_EN
    jump(8'h33);
    trap = 1'b1;
    cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    trap = 1'b0;
    chk("trap_pc", 32'(pc), 32'h10);
    chk("trap_epc", 32'(epc), 32'h33);
    chk("trap_cnt", 32'(ras_cnt), 32'h1);
`endif

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       phase = PH_F;
        1, 2:    phase = PH_W;
        default: phase = 5'b00100;
      endcase
      stall    = ($urandom_range(0, 7) == 0);
      hlt      = ($urandom_range(0, 39) == 0);
      ct_taken = $urandom_range(0, 3) != 0;
      is_call  = 1'($urandom);
      is_ret   = 1'($urandom);
      dr       = 8'($urandom);
`ifdef PC_SEQ_TRAP_EN
      trap     = ($urandom_range(0, 15) == 0);
`endif
      @(posedge clk);
      @(negedge clk);
    end
    hlt = 1'b0; stall = 1'b0; trap = 1'b0; phase = PH_D; ct_taken = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    jump(8'h42);
    cyc(PH_W, 1'b0, 1'b1, 1'b1, 1'b0, 8'h50);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_cnt", 32'(ras_cnt), 32'h0);
    chk("arst_top", 32'(ras_top), 32'h0);
    chk("arst_ovf", 32'(ras_ovf), 32'h0);
    chk("arst_unf", 32'(ras_unf), 32'h0);
`ifdef PC_SEQ_TRAP_EN
    chk("arst_epc", 32'(epc), 32'h0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    cyc(PH_F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_rst", 32'(pc), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
